// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the BCD stopwatch/countdown core.
//   state_t  : run/pause FSM states
//   BCD_W    : bits per decade
//   BCD_MAX  : largest legal BCD digit
//   BCD_MIN  : smallest legal BCD digit
//   bcd_sat(): clamps a 4-bit value to a legal BCD digit
package stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit
// One BCD decade of the stopwatch count. Loads (with saturation to 9),
// increments or decrements when enabled, and reports its terminal value so
// the parent can ripple carry/borrow into the next decade.
// Ports:
//   i_clk, i_rst   : clock, async active-high reset
//   i_en           : step this decade on the next edge
//   i_dn           : 1 = decrement, 0 = increment
//   i_load         : take i_load_val (clamped) on the next edge
//   i_load_val     : raw load digit
//   o_q            : current digit
//   o_tc           : digit is at its wrap point (9 counting up, 0 counting down)
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_dn,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    output logic [BCD_W-1:0] o_q,
    output logic             o_tc
);

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= BCD_MIN;
        end else if (i_load) begin
            r_q <= bcd_sat(i_load_val);
        end else if (i_en) begin
            if (i_dn) begin
                r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
            end else begin
                r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
            end
        end
    end

    assign o_q  = r_q;
    assign o_tc = i_dn ? (r_q == BCD_MIN) : (r_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
// BCD stopwatch / countdown timer. Counts directly in BCD over NUM_DIGITS
// decades, one step every TICK_DIV clocks while running.
// Build option: define STOPWATCH_LAP_EN to include the lap-hold register on
// the display path; without it lap is ignored and lap_hold is 0.
// Ports:
//   clk      : system clock
//   clr      : async active-high reset
//   go       : start / pause / resume / acknowledge pulse
//   mode     : 0 count up, 1 count down (taken when leaving IDLE)
//   load     : copy preset into the count (IDLE and PAUSE only)
//   preset   : BCD load value, digit 0 in the LSBs
//   lap      : toggle lap hold (RUN only)
//   digits   : BCD value to display
//   running  : FSM in RUN
//   done     : FSM in DONE
//   ovf      : one-cycle pulse when an up-count wraps to zero
//   lap_hold : digits frozen on the lap register
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1_000_000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  go,
    input  logic                  mode,
    input  logic                  load,
    input  logic [4*NUM_DIGITS-1:0] preset,
    input  logic                  lap,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                  running,
    output logic                  done,
    output logic                  ovf,
    output logic                  lap_hold
);

    localparam int CW = BCD_W * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t          r_state;
    logic            r_mode;
    logic [PW-1:0]   r_presc;
    logic            r_running;
    logic            r_done;
    logic            r_ovf;

    logic                  w_step;
    logic                  w_load;
    logic                  w_final;
    logic                  w_start_zero;
    logic [NUM_DIGITS:0]   w_en;
    logic [NUM_DIGITS-1:0] w_tc;
    logic [CW-1:0]         w_count;

    assign w_step = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
    assign w_load = load && ((r_state == ST_IDLE) || (r_state == ST_PAUSE));

    // The step that brings a down-count from ...01 to all-zero ends the run.
    assign w_final = w_step && r_mode && (w_count == CW'(1));

    // Zero check for a down start looks at the value the count will hold
    // after this edge, so load+go with a zero preset also goes straight to DONE.
    assign w_start_zero = w_load ? (preset == '0) : (w_count == '0);

    // Ripple enable: a decade steps when every lower decade is at its wrap
    // point. w_en[NUM_DIGITS] is the carry/borrow out of the top decade.
    always_comb begin
        w_en    = '0;
        w_en[0] = w_step;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_en[k+1] = w_en[k] & w_tc[k];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .i_clk      (clk),
            .i_rst      (clr),
            .i_en       (w_en[g]),
            .i_dn       (r_mode),
            .i_load     (w_load),
            .i_load_val (preset[g*BCD_W +: BCD_W]),
            .o_q        (w_count[g*BCD_W +: BCD_W]),
            .o_tc       (w_tc[g])
        );
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_mode    <= 1'b0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ovf <= w_en[NUM_DIGITS] && !r_mode;
            case (r_state)
                ST_IDLE: begin
                    r_presc <= '0;
                    if (go) begin
                        r_mode <= mode;
                        if (mode && w_start_zero) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
                    if (w_final) begin
                        r_state   <= ST_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (go) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (go) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_presc <= '0;
                    if (go) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign running = r_running;
    assign done    = r_done;
    assign ovf     = r_ovf;

`ifdef STOPWATCH_LAP_EN
    logic          r_lap_hold;
    logic [CW-1:0] r_lap;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_lap_hold <= 1'b0;
            r_lap      <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_final) begin
                r_lap_hold <= 1'b0;
            end else if (lap) begin
                r_lap_hold <= !r_lap_hold;
                if (!r_lap_hold) begin
                    r_lap <= w_count;
                end
            end
        end else if (r_state == ST_DONE) begin
            r_lap_hold <= 1'b0;
        end
    end

    assign digits   = r_lap_hold ? r_lap : w_count;
    assign lap_hold = r_lap_hold;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign digits       = w_count;
    assign lap_hold     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
// Bench for stopwatch_core with NUM_DIGITS=2, TICK_DIV=4. Expected display
// values are queued when stimulus is applied and popped when the DUT is
// sampled (1 time unit after the rising edge).
module tb_stopwatch_core;

    localparam int ND = 2;
    localparam int TD = 4;

    logic        clk;
    logic        clr;
    logic        go;
    logic        mode;
    logic        load;
    logic [7:0]  preset;
    logic        lap;
    logic [7:0]  digits;
    logic        running;
    logic        done;
    logic        ovf;
    logic        lap_hold;

    logic [7:0]  q_exp[$];
    logic [7:0]  exp_d;
    logic        exp_h;
    int          n_cmp;
    int          n_bad;

    stopwatch_core #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .clr      (clr),
        .go       (go),
        .mode     (mode),
        .load     (load),
        .preset   (preset),
        .lap      (lap),
        .digits   (digits),
        .running  (running),
        .done     (done),
        .ovf      (ovf),
        .lap_hold (lap_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1; @(posedge clk); #1; go = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; @(posedge clk); #1; lap = 1'b0;
    endtask

    task automatic pulse_load(input logic [7:0] v);
        preset = v; load = 1'b1; @(posedge clk); #1; load = 1'b0;
    endtask

    task automatic pulse_load_go(input logic [7:0] v, input logic m);
        mode = m; preset = v; load = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; go = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #2;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        q_exp.push_back(8'h00);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL reset_digits got %h want %h", digits, exp_d); end
        n_cmp++; if ({running, done, ovf, lap_hold} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {running, done, ovf, lap_hold}); end
        cyc(TD + 1);
        n_cmp++; if (running !== 1'b0 || digits !== 8'h00) begin n_bad++; $display("FAIL reset_idle_hold got run=%b dig=%h want run=0 dig=00", running, digits); end
    endtask

    task automatic test_up_count();
        mode = 1'b0;
        pulse_go();
        mode = 1'b1;                 // must be ignored outside IDLE
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL up_running got %b want 1", running); end
        q_exp.push_back(8'h01);
        cyc(TD);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL up_first_step got %h want %h", digits, exp_d); end
        mode = 1'b0;
        q_exp.push_back(8'h99);
        cyc(TD * 98);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL up_99 got %h want %h", digits, exp_d); end
        cyc(TD - 1);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL up_ovf_early got %b want 0", ovf); end
        q_exp.push_back(8'h00);
        cyc(1);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL up_wrap got %h want %h", digits, exp_d); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL up_ovf_pulse got %b want 1", ovf); end
        cyc(1);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL up_ovf_width got %b want 0", ovf); end
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL up_keeps_running got %b want 1", running); end
    endtask

    // Enters with the count at 00 just after a wrap, prescaler at 1.
    task automatic test_pause();
        cyc(20);                     // count reaches 05
        pulse_go();                  // pause; prescaler frozen at 2
        q_exp.push_back(8'h05);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d || running !== 1'b0) begin n_bad++; $display("FAIL pause_enter got dig=%h run=%b want dig=%h run=0", digits, running, exp_d); end
        q_exp.push_back(8'h05);
        cyc(20);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL pause_hold got %h want %h", digits, exp_d); end
        pulse_go();
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL pause_resume got %b want 1", running); end
        q_exp.push_back(8'h05);
        q_exp.push_back(8'h06);
        cyc(1);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL resume_1cyc got %h want %h", digits, exp_d); end
        cyc(1);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL resume_2cyc got %h want %h", digits, exp_d); end
    endtask

    task automatic test_load_and_clr();
        q_exp.push_back(8'h06);
        pulse_load(8'h50);           // ignored in RUN
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL load_in_run got %h want %h", digits, exp_d); end
        pulse_go();
        q_exp.push_back(8'h37);
        pulse_load(8'h37);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL load_in_pause got %h want %h", digits, exp_d); end
        pulse_go();
        cyc(1);
        n_cmp++; if (running !== 1'b1 || digits !== 8'h37) begin n_bad++; $display("FAIL clr_setup got run=%b dig=%h want run=1 dig=37", running, digits); end
        #2 clr = 1'b1;
        #1;
        q_exp.push_back(8'h00);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d || running !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL clr_async got dig=%h run=%b done=%b want dig=%h run=0 done=0", digits, running, done, exp_d); end
        @(posedge clk); #1;
        clr = 1'b0;
        cyc(TD * 2);
        n_cmp++; if (digits !== 8'h00 || running !== 1'b0) begin n_bad++; $display("FAIL clr_idle got dig=%h run=%b want dig=00 run=0", digits, running); end
    endtask

    task automatic test_countdown();
        pulse_load_go(8'h03, 1'b1);
        q_exp.push_back(8'h03);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d || running !== 1'b1) begin n_bad++; $display("FAIL down_start got dig=%h run=%b want dig=%h run=1", digits, running, exp_d); end
        q_exp.push_back(8'h02);
        q_exp.push_back(8'h01);
        q_exp.push_back(8'h00);
        cyc(TD);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL down_c4 got %h want %h", digits, exp_d); end
        cyc(TD);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d || done !== 1'b0) begin n_bad++; $display("FAIL down_c8 got dig=%h done=%b want dig=%h done=0", digits, done, exp_d); end
        cyc(TD - 1);
        go = 1'b1;                   // collides with the final step; must be dropped
        cyc(1);
        go = 1'b0;
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL down_c12 got %h want %h", digits, exp_d); end
        n_cmp++; if (done !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL down_done got done=%b run=%b want done=1 run=0", done, running); end
        cyc(2);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL down_go_dropped got %b want 1", done); end
        pulse_go();
        n_cmp++; if (done !== 1'b0 || running !== 1'b0) begin n_bad++; $display("FAIL down_ack got done=%b run=%b want 0 0", done, running); end
    endtask

    task automatic test_zero_start();
        mode = 1'b1;
        pulse_go();
        n_cmp++; if (done !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL zero_start got done=%b run=%b want done=1 run=0", done, running); end
        q_exp.push_back(8'h00);
        cyc(TD + 1);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL zero_no_step got %h want %h", digits, exp_d); end
        pulse_go();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_ack got %b want 0", done); end
    endtask

    task automatic test_invalid_preset();
        logic [7:0] pv [3];
        logic [7:0] ev [3];
        pv[0] = 8'hA5; ev[0] = 8'h95;
        pv[1] = 8'hF0; ev[1] = 8'h90;
        pv[2] = 8'h4C; ev[2] = 8'h49;
        for (int i = 0; i < 3; i++) begin
            q_exp.push_back(ev[i]);
            pulse_load(pv[i]);
            exp_d = q_exp.pop_front();
            n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL preset_sat[%0d] got %h want %h", i, digits, exp_d); end
        end
    endtask

    task automatic test_lap();
`ifdef STOPWATCH_LAP_EN
        exp_h = 1'b1;
`else
        exp_h = 1'b0;
`endif
        pulse_load_go(8'h00, 1'b0);
        cyc(TD * 7);
        q_exp.push_back(8'h07);
        pulse_lap();
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d || lap_hold !== exp_h) begin n_bad++; $display("FAIL lap_take got dig=%h hold=%b want dig=%h hold=%b", digits, lap_hold, exp_d, exp_h); end
        q_exp.push_back(exp_h ? 8'h07 : 8'h08);
        cyc(TD - 1);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL lap_frozen got %h want %h", digits, exp_d); end
        q_exp.push_back(exp_h ? 8'h07 : 8'h12);
        cyc(TD * 4);
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL lap_frozen_long got %h want %h", digits, exp_d); end
        q_exp.push_back(8'h12);
        pulse_lap();
        exp_d = q_exp.pop_front();
        n_cmp++; if (digits !== exp_d || lap_hold !== 1'b0) begin n_bad++; $display("FAIL lap_release got dig=%h hold=%b want dig=%h hold=0", digits, lap_hold, exp_d); end
        pulse_go();
        pulse_lap();                 // ignored in PAUSE
        n_cmp++; if (lap_hold !== 1'b0) begin n_bad++; $display("FAIL lap_in_pause got %b want 0", lap_hold); end
        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        pulse_load_go(8'h02, 1'b1);
        pulse_lap();
        n_cmp++; if (lap_hold !== exp_h) begin n_bad++; $display("FAIL lap_down_take got %b want %b", lap_hold, exp_h); end
        q_exp.push_back(8'h00);
        cyc(TD * 2 - 1);
        exp_d = q_exp.pop_front();
        n_cmp++; if (done !== 1'b1 || lap_hold !== 1'b0 || digits !== exp_d) begin n_bad++; $display("FAIL lap_done_release got done=%b hold=%b dig=%h want 1 0 %h", done, lap_hold, digits, exp_d); end
        pulse_go();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        clr = 1'b1; go = 1'b0; mode = 1'b0; load = 1'b0; preset = 8'h00; lap = 1'b0;
        test_reset();
        test_up_count();
        test_pause();
        test_load_and_clr();
        test_countdown();
        test_zero_start();
        test_invalid_preset();
        test_lap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
